// File: rtl/l2_arbiter_if.sv
// Wishbone bundle between the two L1 caches, the arbiter and the L2 slave port.
// The slave modport is the arbiter's view; master is the L1/L2 environment view.
interface l2_arbiter_if #(
  parameter int ADR_W = 12,
  parameter int DAT_W = 128,
  parameter int SEL_W = 16
);
  logic [ADR_W-1:0] i_adr;
  logic [DAT_W-1:0] i_dat_m;
  logic [SEL_W-1:0] i_sel;
  logic             i_cyc;
  logic             i_stb;
  logic             i_we;
  logic [DAT_W-1:0] i_dat_s;
  logic             i_ack;
  logic             i_rty;

  logic [ADR_W-1:0] d_adr;
  logic [DAT_W-1:0] d_dat_m;
  logic [SEL_W-1:0] d_sel;
  logic             d_cyc;
  logic             d_stb;
  logic             d_we;
  logic [DAT_W-1:0] d_dat_s;
  logic             d_ack;
  logic             d_rty;

  logic [ADR_W-1:0] l2_adr;
  logic [DAT_W-1:0] l2_dat_m;
  logic [SEL_W-1:0] l2_sel;
  logic             l2_cyc;
  logic             l2_stb;
  logic             l2_we;
  logic [DAT_W-1:0] l2_dat_s;
  logic             l2_ack;

  modport slave (
    input  i_adr, i_dat_m, i_sel, i_cyc, i_stb, i_we,
    output i_dat_s, i_ack, i_rty,
    input  d_adr, d_dat_m, d_sel, d_cyc, d_stb, d_we,
    output d_dat_s, d_ack, d_rty,
    output l2_adr, l2_dat_m, l2_sel, l2_cyc, l2_stb, l2_we,
    input  l2_dat_s, l2_ack
  );

  modport master (
    output i_adr, i_dat_m, i_sel, i_cyc, i_stb, i_we,
    input  i_dat_s, i_ack, i_rty,
    output d_adr, d_dat_m, d_sel, d_cyc, d_stb, d_we,
    input  d_dat_s, d_ack, d_rty,
    input  l2_adr, l2_dat_m, l2_sel, l2_cyc, l2_stb, l2_we,
    output l2_dat_s, l2_ack
  );
endinterface

// File: rtl/l2_arbiter.sv
// Round-robin arbiter letting the L1 I-cache and D-cache share the L2 Wishbone
// slave; a grant lasts one line transaction and grants are counted per port.
module l2_arbiter #(
  parameter int CNT_W   = 16,
  parameter bit D_FIRST = 1'b1
) (
  input  logic             clk,
  input  logic             rst_n,
  l2_arbiter_if.slave      bus,
  output logic [CNT_W-1:0] i_grant_cnt,
  output logic [CNT_W-1:0] d_grant_cnt
);

  typedef enum logic [1:0] {IDLE, GRANT_I, GRANT_D} state_t;

  state_t state;
  state_t state_nxt;
  logic   last_d;
  logic   req_i;
  logic   req_d;

  assign req_i = bus.i_cyc & bus.i_stb;
  assign req_d = bus.d_cyc & bus.d_stb;

  // last_d starts opposite to the port that should win the first tie
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= IDLE;
      last_d      <= ~D_FIRST;
      i_grant_cnt <= '0;
      d_grant_cnt <= '0;
    end else begin
      state <= state_nxt;
      if (state == IDLE && state_nxt == GRANT_I) begin
        last_d      <= 1'b0;
        i_grant_cnt <= i_grant_cnt + CNT_W'(1);
      end
      if (state == IDLE && state_nxt == GRANT_D) begin
        last_d      <= 1'b1;
        d_grant_cnt <= d_grant_cnt + CNT_W'(1);
      end
    end
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE: begin
        if (req_i && req_d) state_nxt = last_d ? GRANT_I : GRANT_D;
        else if (req_i)     state_nxt = GRANT_I;
        else if (req_d)     state_nxt = GRANT_D;
      end
      // an ack ends the line; dropping cyc aborts it, the grant stays counted
      GRANT_I: if (bus.l2_ack || !bus.i_cyc) state_nxt = IDLE;
      GRANT_D: if (bus.l2_ack || !bus.d_cyc) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    bus.l2_adr   = bus.d_adr;
    bus.l2_dat_m = bus.d_dat_m;
    bus.l2_sel   = bus.d_sel;
    bus.l2_cyc   = 1'b0;
    bus.l2_stb   = 1'b0;
    bus.l2_we    = 1'b0;
    bus.i_ack    = 1'b0;
    bus.d_ack    = 1'b0;
    case (state)
      GRANT_I: begin
        bus.l2_adr   = bus.i_adr;
        bus.l2_dat_m = bus.i_dat_m;
        bus.l2_sel   = bus.i_sel;
        bus.l2_cyc   = bus.i_cyc;
        bus.l2_stb   = bus.i_stb;
        bus.l2_we    = bus.i_we;
        bus.i_ack    = bus.l2_ack;
      end
      GRANT_D: begin
        bus.l2_cyc   = bus.d_cyc;
        bus.l2_stb   = bus.d_stb;
        bus.l2_we    = bus.d_we;
        bus.d_ack    = bus.l2_ack;
      end
      default: ;
    endcase
  end

  assign bus.i_dat_s = bus.l2_dat_s;
  assign bus.d_dat_s = bus.l2_dat_s;
  assign bus.i_rty   = req_i & ~bus.i_ack;
  assign bus.d_rty   = req_d & ~bus.d_ack;

endmodule

// File: doc/l2_arbiter.md
Name: l2_arbiter

Overview:
- Two-master to one-slave Wishbone arbiter in front of the unified L2 cache.
- The L1 instruction cache (port i_*) and the L1 data cache (port d_*) share a single L2 slave interface (port l2_*).
- Granting is round-robin. A grant is held for one full line transaction, and each grant is counted per port for performance monitoring.
- Sits between the L1 caches and the l2cache wb_cpu_cache slave port.

Parameters:
- ADR_W, 12, line-address width; byte address bits [15:4].
- DAT_W, 128, line data width (lc3b_8words).
- SEL_W, 16, byte-select width.
- CNT_W, 16, width of the per-port grant counters.
- D_FIRST, 1, which port wins the first tie after reset: 1 = data cache, 0 = instruction cache.

Ports:
- clk in 1: sole clock, rising edge.
- rst_n in 1: asynchronous, active-low reset.
- i_adr in ADR_W: I-cache line address.
- i_dat_m in DAT_W: I-cache write data.
- i_sel in SEL_W: I-cache byte selects.
- i_cyc in 1, i_stb in 1, i_we in 1: I-cache Wishbone controls.
- i_dat_s out DAT_W: read data returned to the I-cache.
- i_ack out 1, i_rty out 1: I-cache acknowledge and retry.
- d_adr, d_dat_m, d_sel, d_cyc, d_stb, d_we, d_dat_s, d_ack, d_rty: same as the i_* set, for the D-cache.
- l2_adr out ADR_W, l2_dat_m out DAT_W, l2_sel out SEL_W, l2_cyc out 1, l2_stb out 1, l2_we out 1: to the L2 slave.
- l2_dat_s in DAT_W, l2_ack in 1: from the L2 slave.
- i_grant_cnt out CNT_W, d_grant_cnt out CNT_W: grants issued per port.

Behaviour:
- Request definition: req_x = x_cyc & x_stb.
- State register: IDLE, GRANT_I, GRANT_D, plus a 1-bit last register (last granted port).
- Reset (asynchronous, immediate):
  - state = IDLE; last = I if D_FIRST = 1, else D (so D wins the first tie when D_FIRST = 1).
  - Both counters = 0.
  - All l2_cyc/l2_stb/l2_we = 0; all acks = 0.
  - Reset asserted mid-transaction drops l2_cyc in the same cycle; no completion is reported to either master.
- IDLE transitions:
  - Only one port requesting: go to that port's GRANT state.
  - Both requesting: grant the port that is NOT last.
  - No request: stay in IDLE.
  - On every grant: update last and increment that port's counter. Counters wrap 2^CNT_W-1 -> 0 with no saturation.
- GRANT_x outputs (combinational from the state register):
  - l2_adr/l2_dat_m/l2_sel/l2_we follow port x.
  - l2_cyc = x_cyc, l2_stb = x_stb.
  - x_dat_s = l2_dat_s, x_ack = l2_ack.
- Outputs in every other case:
  - l2_cyc = l2_stb = l2_we = 0 in IDLE.
  - l2_adr/dat_m/sel are driven from the D port in IDLE; this value is don't-care.
  - Non-granted port: ack = 0; dat_s = l2_dat_s (don't-care without ack).
- Retry: x_rty = req_x & ~x_ack for both ports in every state. A waiting or stalled master therefore sees rty = 1.
- Leaving GRANT_x:
  - l2_ack = 1 in GRANT_x: return to IDLE next cycle.
  - x_cyc drops before ack (abort): return to IDLE next cycle; the counter is NOT decremented.
  - Otherwise hold GRANT_x indefinitely; there is no timeout.
- Request-to-slave latency: a request seen in IDLE at edge N gives l2_stb = 1 during cycle N+1.
- Back-to-back:
  - Each transaction passes through at least one IDLE cycle, so the minimum spacing between l2_stb assertions is ack + 1 cycle.
  - A master re-requesting while the other port waits loses to it, which gives strict alternation under contention.
- Simultaneous ack and new request from the other port: the ack is routed to the current owner. The other port is evaluated in the following IDLE cycle.
- An l2_ack arriving in IDLE is ignored; it is not forwarded to either port.

Test Plan:
- Reset with D_FIRST = 1, then i_cyc = i_stb = 1 only, i_adr = 12'h0A3 -> l2_stb = 1 in the next cycle with l2_adr = 12'h0A3. L2 acks after 3 cycles -> i_ack = 1 for exactly that cycle, i_rty = 1 in the 3 cycles before, i_grant_cnt = 1, d_grant_cnt = 0.
- Both ports request in the same cycle after reset -> D granted first. After D's ack, the state passes through one IDLE cycle, then I is granted. d_rty = 0 only on D's ack cycle; i_rty = 1 until I's ack. Counters end at 1 and 1.
- Both ports hold requests continuously for 6 transactions -> grant order D, I, D, I, D, I; counters 3 and 3; l2_ack is never visible on the non-owner port.
- D granted with d_we = 1 and d_dat_m = 128'hDEAD..BEEF, then D drops d_cyc before any ack -> l2_cyc = 0 within one cycle, the arbiter returns to IDLE, d_grant_cnt stays incremented, and a pending I request is granted next.
- rst_n pulsed low mid-way through an I transaction -> l2_cyc, l2_stb and i_ack fall combinationally and the counters read 0. After release, the pending I request is re-granted.
- Preload i_grant_cnt = 16'hFFFF via 65535 I grants, then one more I grant -> i_grant_cnt = 0, with no effect on d_grant_cnt.
